// File: rtl/mdu_divider.sv
// mdu_divider: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Quotient feeds LO, remainder feeds HI; done pulses once per accepted start.
`default_nettype none

module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvsr, dividend_q;
  logic             neg_quo, neg_rem, dbz_q;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic [WIDTH:0]   trial, diff;

  assign dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Partial remainder stays below 2*divisor, so a WIDTH+1 bit difference
  // never overflows and its MSB is a valid sign.
  assign trial = {rem, quo[WIDTH-1]};
  assign diff  = trial - {1'b0, dvsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      dividend_q  <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            dividend_q <= dividend;
            quo        <= dividend_abs;
            dvsr       <= divisor_abs;
            rem        <= '0;
            count      <= '0;
            neg_quo    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem    <= is_signed & dividend[WIDTH-1];
            dbz_q      <= (divisor == '0);
          end
        end
        CALC: begin
          // The cycle with count==LAST only hands over to FIX, keeping
          // the total latency at WIDTH+2 edges.
          if (count != LAST) begin
            rem   <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            count <= count + CW'(1);
          end
        end
        FIX: begin
          if (dbz_q) begin
            quotient  <= '1;
            remainder <= dividend_q;
          end else begin
            quotient  <= neg_quo ? -quo : quo;
            remainder <= neg_rem ? -rem : rem;
          end
          div_by_zero <= dbz_q;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_divider.sv
// Scoreboard bench for mdu_divider: driver pushes model results, monitor
// pops and compares on every done pulse.
`default_nettype none

module tb_mdu_divider;

  localparam int W   = 32;
  localparam int LAT = W + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  mdu_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int unsigned  due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, C-style truncation for signed.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t   e;
    longint sa, sb_;
    longint sq, sr;
    e.due = 0;
    e.z   = (b == 0);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else if (s) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      sq  = sa / sb_;
      sr  = sa % sb_;
      e.q = sq[W-1:0];
      e.r = sr[W-1:0];
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit expect_it);
    exp_t e;
    int   g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("idle_wait_timeout", 64'(busy), 64'd0);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    if (expect_it) begin
      e     = model(a, b, s);
      e.due = cyc + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Monitor
  logic         prev_done = 1'b0;
  logic         prev_busy = 1'b0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (done) begin
        chk("done_width", 64'(prev_done), 64'd0);
        chk("busy_in_done", 64'(busy), 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("remainder", 64'(remainder), 64'(e.r));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.z));
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end
      if (busy && prev_busy)
        chk("stable_during_busy", {quotient, remainder}, {last_q, last_r});
    end
    prev_done = done;
    prev_busy = busy;
    last_q    = quotient;
    last_r    = remainder;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    int           g;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_outputs", {quotient, remainder}, 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    // Directed signs and boundaries, issued back-to-back
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    issue(32'hFFFFFFFF, 32'h10, 1'b0, 1'b1);
    issue(32'hFFFFFFF9, 32'h2, 1'b1, 1'b1);
    issue(32'h7, 32'hFFFFFFFE, 1'b1, 1'b1);
    issue(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b1);
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    issue(32'h5, 32'h0, 1'b0, 1'b1);
    issue(32'h5, 32'h0, 1'b1, 1'b1);
    issue(32'hFFFFFFF9, 32'h0, 1'b1, 1'b1);

    // Start while busy must be ignored
    issue(32'd1000, 32'd3, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    dividend = 32'd77; divisor = 32'd5; is_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Mid-operation reset aborts with no done
    issue(32'd123456, 32'd789, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_outputs", {quotient, remainder}, 64'd0);
    chk("async_reset_flags", {62'd0, done, div_by_zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    issue(32'd123456, 32'd789, 1'b0, 1'b1);

    // Random regression
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = b >> $urandom_range(1, 31);
        1: b = 32'(int'($urandom_range(0, 9)) - 5);
        2: a = 32'h80000000;
        default: ;
      endcase
      if (b == 0) b = 32'd1;
      issue(a, b, 1'(($urandom & 1)), 1'b1);
    end

    g = 0;
    while (sb.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
